// File: rtl/voice_mult.sv
// Serial shift-add multiplier: scales a signed 12-bit voice sample by an 8-bit envelope level.
// Optional voice 0-2 mix accumulator is enabled by defining VOICE_MULT_MIX_ACCUM_EN.
module voice_mult (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  voice_idx_i,
  input  logic [11:0] wave_i,
  input  logic [7:0]  env_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [19:0] prod_o,
  output logic [11:0] voice_o,
  output logic [13:0] mix_o,
  output logic        mix_valid_o
);

  localparam int unsigned PW = 20;
  localparam int unsigned WW = 12;
  localparam int unsigned EW = 8;
  localparam int unsigned VW = 12;
  localparam int unsigned MW = 14;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [EW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]   pacc_q, pacc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [VW-1:0]   voice_q, voice_d;

  // Multiply sequencing: operand latch, 8 add/shift iterations, result load.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    pacc_d   = pacc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    prod_d   = prod_q;
    voice_d  = voice_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d  = {{(PW-WW){wave_i[WW-1]}}, wave_i};
          mplier_d = env_i;
          pacc_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_MULT;
        end
      end
      ST_MULT: begin
        if (mplier_q[0]) begin
          pacc_d = pacc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        prod_d  = pacc_q;
        voice_d = pacc_q[PW-1:PW-VW];
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      pacc_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      prod_q   <= '0;
      voice_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      pacc_q   <= pacc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      prod_q   <= prod_d;
      voice_q  <= voice_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign prod_o  = prod_q;
  assign voice_o = voice_q;

`ifdef VOICE_MULT_MIX_ACCUM_EN
  logic [1:0]    idx_q, idx_d;
  logic [MW-1:0] macc_q, macc_d;
  logic [MW-1:0] mix_q, mix_d;
  logic          mix_valid_q, mix_valid_d;
  logic [MW-1:0] voice_ext;

  assign voice_ext = {{(MW-VW){pacc_q[PW-1]}}, pacc_q[PW-1:PW-VW]};

  // Voice 0 restarts the mix, voices 1/2 add in, voice 2 publishes; index 3 is ignored.
  always_comb begin
    idx_d       = idx_q;
    macc_d      = macc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    if ((state_q == ST_IDLE) && start_i) begin
      idx_d = voice_idx_i;
    end
    if (state_q == ST_DONE) begin
      case (idx_q)
        2'd0:       macc_d = voice_ext;
        2'd1, 2'd2: macc_d = macc_q + voice_ext;
        default:    macc_d = macc_q;
      endcase
      if (idx_q == 2'd2) begin
        mix_d       = macc_d;
        mix_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      macc_q      <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      macc_q      <= macc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign mix_o       = mix_q;
  assign mix_valid_o = mix_valid_q;
`else
  logic unused_idx;
  assign unused_idx  = ^voice_idx_i;
  assign mix_o       = '0;
  assign mix_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_voice_mult.sv
// Randomized scoreboard bench for voice_mult; expected products come from plain integer arithmetic.
module tb_voice_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  voice_idx = '0;
  logic [11:0] wave = '0;
  logic [7:0]  env = '0;
  logic        busy_o, ready_o, mix_valid_o;
  logic [19:0] prod_o;
  logic [11:0] voice_o;
  logic [13:0] mix_o;

  int n_vec = 0;
  int n_err = 0;
  int exp_prod_q[$];
  int exp_voice_q[$];
  int exp_mix_q[$];
  int model_mix = 0;
  bit chk_pending = 1'b0;

  voice_mult dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .voice_idx_i (voice_idx),
    .wave_i      (wave),
    .env_i       (env),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .prod_o      (prod_o),
    .voice_o     (voice_o),
    .mix_o       (mix_o),
    .mix_valid_o (mix_valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Monitor: results appear the cycle after the ready pulse.
  always @(negedge clk) begin
    int ep, ev, em;
    if (chk_pending) begin
      chk_pending = 1'b0;
      ep = exp_prod_q.pop_front();
      ev = exp_voice_q.pop_front();
      n_vec++;
      if (int'($signed(prod_o)) != ep) begin
        n_err++;
        $display("FAIL prod: got %0d want %0d", int'($signed(prod_o)), ep);
      end
      n_vec++;
      if (int'($signed(voice_o)) != ev) begin
        n_err++;
        $display("FAIL voice: got %0d want %0d", int'($signed(voice_o)), ev);
      end
    end
    if (ready_o === 1'b1) begin
      if (exp_prod_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ready: unexpected ready pulse at %0t", $time);
      end else begin
        chk_pending = 1'b1;
      end
    end
`ifdef VOICE_MULT_MIX_ACCUM_EN
    if (mix_valid_o === 1'b1) begin
      n_vec++;
      if (exp_mix_q.size() == 0) begin
        n_err++;
        $display("FAIL mix_valid: unexpected pulse, mix %0d", int'($signed(mix_o)));
      end else begin
        em = exp_mix_q.pop_front();
        if (int'($signed(mix_o)) != em) begin
          n_err++;
          $display("FAIL mix: got %0d want %0d", int'($signed(mix_o)), em);
        end
      end
    end
`else
    if (ready_o === 1'b1) begin
      n_vec++;
      if (mix_o !== 14'd0 || mix_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL mix_off: got mix %0d valid %0b want 0 0", mix_o, mix_valid_o);
      end
    end
`endif
  end

  task automatic check_zero(input string tag);
    n_vec++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || prod_o !== 20'd0 || voice_o !== 12'd0 ||
        mix_o !== 14'd0 || mix_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got busy %b ready %b prod %0d voice %0d mix %0d mv %b want all 0",
               tag, busy_o, ready_o, prod_o, voice_o, mix_o, mix_valid_o);
    end
  endtask

  // Issues one multiply with start sampled at the next edge; checks busy/ready per cycle.
  // glitch: inject ignored starts and an operand change; rst_at: abort with reset in that cycle.
  task automatic run_op(input logic [11:0] w, input logic [7:0] e, input logic [1:0] idx,
                        input bit glitch, input int rst_at);
    int p, v;
    start = 1'b1;
    wave = w;
    env = e;
    voice_idx = idx;
    p = int'($signed(w)) * int'(e);
    v = p >>> 8;
    if (rst_at == 0) begin
      exp_prod_q.push_back(p);
      exp_voice_q.push_back(v);
      if (idx == 2'd0) model_mix = v;
      else if (idx != 2'd3) model_mix += v;
      if (idx == 2'd2) exp_mix_q.push_back(model_mix);
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rst_at != 0 && c == rst_at + 1) begin
        check_zero("reset_abort");
        model_mix = 0;
        rst_n = 1'b1;
        return;
      end
      if (glitch && (c == 4 || c == 10)) start = 1'b0;
      n_vec++;
      if (busy_o !== (c <= 9)) begin
        n_err++;
        $display("FAIL busy c%0d: got %b want %b", c, busy_o, (c <= 9));
      end
      n_vec++;
      if (ready_o !== (c == 9)) begin
        n_err++;
        $display("FAIL ready c%0d: got %b want %b", c, ready_o, (c == 9));
      end
      if (rst_at != 0 && c == rst_at) rst_n = 1'b0;
      if (glitch && c == 3) wave = 12'hffb;
      if (glitch && (c == 3 || c == 9)) start = 1'b1;
    end
  endtask

  initial begin
    logic [11:0] rw;
    logic [7:0]  re;
    logic [1:0]  ri;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(12'd1000, 8'd128, 2'd0, 1'b0, 0);
    run_op(12'he00, 8'd255, 2'd1, 1'b0, 0);
    run_op(12'd256,  8'd64,  2'd2, 1'b0, 0);
    run_op(12'd1000, 8'd255, 2'd3, 1'b0, 0);
    run_op(12'h7ff,  8'hff,  2'd0, 1'b0, 0);
    run_op(12'h800,  8'hff,  2'd1, 1'b0, 0);
    run_op(12'hfff,  8'h01,  2'd2, 1'b0, 0);
    run_op(12'h5a5,  8'h00,  2'd0, 1'b0, 0);
    run_op(12'd300,  8'd2,   2'd3, 1'b1, 0);
    run_op(12'd77,   8'd9,   2'd1, 1'b0, 0);
    run_op(12'h321,  8'h99,  2'd0, 1'b0, 5);
    run_op(12'h123,  8'h45,  2'd2, 1'b0, 0);

    for (int i = 0; i < 48; i++) begin
      rw = 12'($urandom);
      re = 8'($urandom);
      ri = 2'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(rw, re, ri, 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_prod_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results outstanding want 0", exp_prod_q.size());
    end
`ifdef VOICE_MULT_MIX_ACCUM_EN
    n_vec++;
    if (exp_mix_q.size() != 0) begin
      n_err++;
      $display("FAIL mix_drain: got %0d mixes outstanding want 0", exp_mix_q.size());
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/voice_mult.md
# voice_mult

Serial shift-add multiplier that scales one voice's signed waveform sample by its 8-bit envelope level. It sits directly downstream of the envelope generator and answers its `mult_start`/`mult_ready` handshake. It is time-shared across voices 0–2 within each sample period. An optional accumulator sums the three scaled voices into a mix word for the output stage.

## Interface
Parameters: none.

- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, active-low; one clock; reset is synchronous and active-low
- `start_i`  in  1  start request; driven by the envelope block's mult start
- `voice_idx_i`  in  2  voice being processed (0–2), sampled with `start_i`
- `wave_i`  in  12  signed waveform sample (two's complement)
- `env_i`  in  8  unsigned envelope level, 0x00–0xFF
- `busy_o`  out  1  high while a multiply is in progress
- `ready_o`  out  1  one-cycle done pulse; drives the envelope block's mult ready
- `prod_o`  out  20  signed full product `wave_i * env_i`
- `voice_o`  out  12  signed scaled product, `prod_o[19:8]`
- `mix_o`  out  14  signed sum of voice 0–2 `voice_o` (see Configuration)
- `mix_valid_o`  out  1  one-cycle pulse when `mix_o` is complete

## Operation
- States: IDLE, MULT, DONE.
- **IDLE.** When `start_i=1`, latch the operands:
  - `wave_i`, sign-extended to 20 bits, into the multiplicand register.
  - `env_i` into the multiplier shift register.
  - `voice_idx_i` into the index register.
  - Clear the product accumulator, clear the 3-bit bit counter, go to MULT.
- **MULT.** Each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the product.
  - Then shift the multiplicand left 1 and the multiplier right 1, and increment the counter.
  - After the counter reaches 7 (8 iterations), go to DONE.
- **DONE.** Assert `ready_o` and load the `prod_o`/`voice_o` output registers, then return to IDLE.
- Latency is fixed. There is no early termination for `env_i=0` or leading zero bits.
- **Width rule.** The product is 20-bit signed and cannot overflow: range −522240..+521985.
- **Scaling.** `voice_o = prod_o >>> 8`, truncated toward −∞.
- **Outputs.** `prod_o`/`voice_o` hold the last result until the next DONE.
- **Start while busy.** `start_i` in MULT or DONE is ignored; there is no queueing and no error flag.
- **Operand changes.** Changes on `wave_i`/`env_i` after the start cycle have no effect on the running multiply.
- **Bad index.** `voice_idx_i=3` is multiplied normally but excluded from mix accumulation.

## Timing
- Start sampled at edge k:
  - `busy_o=1` in cycles k+1..k+9.
  - `ready_o=1` exactly in cycle k+9.
  - `prod_o`/`voice_o` are valid from cycle k+10.
- Back-to-back: the next `start_i` is accepted in cycle k+10 at the earliest (IDLE), giving a 10-cycle period per voice.
- `start_i` may be held high. Each acceptance from IDLE starts one multiply, so a continuously high start restarts every 10 cycles.
- Reset values: state IDLE; `busy_o`, `ready_o`, `mix_valid_o` = 0; `prod_o`, `voice_o`, `mix_o` and all internal registers = 0.
- Reset mid-operation: the next edge with `rst_ni=0` aborts and forces reset values. No `ready_o` is emitted for the aborted operation.

## Configuration
- Macro `VOICE_MULT_MIX_ACCUM_EN`.
- **Defined:**
  - A 14-bit signed mix accumulator is updated in the DONE cycle.
  - Voice 0 loads `acc = voice_result`; voice 1 or 2 does `acc += voice_result`.
  - On voice 2's DONE, `mix_o` registers the final sum and `mix_valid_o` pulses in the following cycle.
  - `mix_o` holds until the next voice 2 completion.
  - Voice index 3 leaves the accumulator untouched.
  - Range is ±6120, so there is no overflow.
- **Undefined:** no accumulator logic; `mix_o` is tied to 0 and `mix_valid_o` is tied to 0.

## Test plan
- `wave_i=1000`, `env_i=128`, start pulse at cycle 0 → `busy_o` high cycles 1–9; `ready_o` only at cycle 9; `prod_o=128000`, `voice_o=500`.
- Extremes:
  - `wave_i=2047`, `env_i=0xFF` → `prod_o=521985`, `voice_o=2039`.
  - `wave_i=-2048`, `env_i=0xFF` → `prod_o=-522240`, `voice_o=-2040`.
  - `wave_i=-1`, `env_i=1` → `voice_o=-1`.
  - `env_i=0` → `prod_o=0`, still 9-cycle latency.
- Operand/start isolation:
  - Start with `wave_i=300`, `env_i=2`.
  - Change `wave_i` to −5 and pulse `start_i` at cycles 3 and 9.
  - Required: exactly one `ready_o` (cycle 9), `prod_o=600`; `start_i` at cycle 10 accepted.
- Reset mid-operation: assert `rst_ni=0` at cycle 5 of a multiply → next cycle all outputs 0, state IDLE, no `ready_o`; a new start after reset release completes normally.
- Mix with macro defined: voices 0/1/2 with (`wave_i`, `env_i`) = (1000,128), (−512,255), (256,64):
  - `voice_o` = 500, −510, 64.
  - `mix_valid_o` pulses once with `mix_o=54`.
  - Then voice 3 with (1000,255) → `mix_o` stays 54.
- Macro undefined: same sequence → `voice_o` values identical, `mix_o=0` and `mix_valid_o=0` throughout.
